// File: rtl/bus_pkg.sv
// Shared constants and types for the ISP pixel bus.
// FIFO geometry, default video timing, pixel word type and the
// timing generator state encoding.
package bus_pkg;
  localparam int FIFO_DEPTH = 512;
  localparam int USEDW_W    = $clog2(FIFO_DEPTH);

  // Default video timing; the top exposes these as overridable parameters.
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_H_BLANK  = 16;
  localparam int DEF_V_BLANK  = 4;
  localparam int HS_WIDTH     = 8;  // HS pulse, pixel periods at start of H blank
  localparam int VS_WIDTH     = 2;  // VS pulse, lines at start of V blank

  typedef logic [31:0] pixel_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } vstate_e;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Ports: clk, reset (sync, active-high), push/din, pop/head,
//        empty, full, usedw (count modulo DEPTH; full disambiguates DEPTH).
// head is the oldest word while non-empty and 0 when empty.
// Push while full is dropped; pop while empty is ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH)-1:0] usedw
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign usedw   = cnt[AW-1:0];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is not reset: contents are dead once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/bus.sv
// ISP pixel bus: camera words -> write FIFO -> transfer -> read FIFO ->
// video timing generator -> VPG interface.
// Ports: ctrl_clk/reset (sync, active-high); iData/sCCD_DVAL camera input;
//        read_init starts video output (sticky until reset);
//        Read_DATA read FIFO head; vpg_pclk/de/hs/vs/data video output;
//        FIFO empty/full flags and usedw counts for debug.
module bus
  import bus_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_BLANK  = DEF_V_BLANK
) (
  input  logic               ctrl_clk,
  input  logic               reset,
  input  pixel_t             iData,
  input  logic               sCCD_DVAL,
  input  logic               read_init,
  output pixel_t             Read_DATA,
  output logic               vpg_pclk,
  output logic               vpg_de,
  output logic               vpg_hs,
  output logic               vpg_vs,
  output logic [23:0]        vpg_data,
  output logic               read_empty_rdfifo,
  output logic               write_full_rdfifo,
  output logic               read_empty_wrfifo,
  output logic               write_full_wrfifo,
  output logic [USEDW_W-1:0] write_fifo_wrusedw,
  output logic [USEDW_W-1:0] write_fifo_rdusedw,
  output logic [USEDW_W-1:0] read_fifo_wrusedw,
  output logic [USEDW_W-1:0] read_fifo_rdusedw
);
  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + HS_WIDTH);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + VS_WIDTH);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

  // FIFO plumbing
  pixel_t             wr_head;
  logic               xfer, rd_pop;
  logic [USEDW_W-1:0] wr_usedw, rd_usedw;

  // Move one word per cycle whenever there is something to move and room for it.
  assign xfer = ~read_empty_wrfifo & ~write_full_rdfifo;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(pixel_t))) u_wrfifo (
    .clk   (ctrl_clk),
    .reset (reset),
    .push  (sCCD_DVAL),
    .pop   (xfer),
    .din   (iData),
    .head  (wr_head),
    .empty (read_empty_wrfifo),
    .full  (write_full_wrfifo),
    .usedw (wr_usedw)
  );

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(pixel_t))) u_rdfifo (
    .clk   (ctrl_clk),
    .reset (reset),
    .push  (xfer),
    .pop   (rd_pop),
    .din   (wr_head),
    .head  (Read_DATA),
    .empty (read_empty_rdfifo),
    .full  (write_full_rdfifo),
    .usedw (rd_usedw)
  );

  assign write_fifo_wrusedw = wr_usedw;
  assign write_fifo_rdusedw = wr_usedw;
  assign read_fifo_wrusedw  = rd_usedw;
  assign read_fifo_rdusedw  = rd_usedw;

  // Start latch as a two-state FSM
  vstate_e state, state_nxt;

  always_ff @(posedge ctrl_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE && read_init) state_nxt = ST_RUN;
  end

  // Timing generator
  logic          run, strobe;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  assign run    = (state == ST_RUN);
  // pclk is about to rise: one pixel period ends on this edge.
  assign strobe = run & ~vpg_pclk;
  // The word shown during an active pixel is consumed at the end of that pixel.
  assign rd_pop = strobe & vpg_de & ~read_empty_rdfifo;

  always_ff @(posedge ctrl_clk) begin
    if (reset) begin
      vpg_pclk <= 1'b0;
      vpg_de   <= 1'b0;
      vpg_hs   <= 1'b0;
      vpg_vs   <= 1'b0;
      hcnt     <= '0;
      vcnt     <= '0;
    end else begin
      if (run) vpg_pclk <= ~vpg_pclk;
      if (strobe) begin
        // Outputs for the pixel at (hcnt, vcnt), then step to the next one.
        vpg_de <= (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        vpg_hs <= (hcnt >= H_ACT_C) && (hcnt < HS_END_C);
        vpg_vs <= (vcnt >= V_ACT_C) && (vcnt < VS_END_C);
        if (hcnt == H_LAST_C) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST_C) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  // Underflow during active video shows black rather than stale data.
  assign vpg_data = (vpg_de && !read_empty_rdfifo) ? Read_DATA[23:0] : 24'h0;
endmodule

// File: tb/tb_bus.sv
module tb_bus;
  import bus_pkg::*;

  localparam int HA = 320;
  localparam int HB = 16;
  localparam int VA = 6;
  localparam int VB = 4;

  logic         ctrl_clk = 1'b0;
  logic         reset, sCCD_DVAL, read_init;
  pixel_t       iData, Read_DATA;
  logic         vpg_pclk, vpg_de, vpg_hs, vpg_vs;
  logic [23:0]  vpg_data;
  logic         re_rd, wf_rd, re_wr, wf_wr;
  logic [8:0]   wfw, wfr, rfw, rfr;

  bus #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .ctrl_clk           (ctrl_clk),
    .reset              (reset),
    .iData              (iData),
    .sCCD_DVAL          (sCCD_DVAL),
    .read_init          (read_init),
    .Read_DATA          (Read_DATA),
    .vpg_pclk           (vpg_pclk),
    .vpg_de             (vpg_de),
    .vpg_hs             (vpg_hs),
    .vpg_vs             (vpg_vs),
    .vpg_data           (vpg_data),
    .read_empty_rdfifo  (re_rd),
    .write_full_rdfifo  (wf_rd),
    .read_empty_wrfifo  (re_wr),
    .write_full_wrfifo  (wf_wr),
    .write_fifo_wrusedw (wfw),
    .write_fifo_rdusedw (wfr),
    .read_fifo_wrusedw  (rfw),
    .read_fifo_rdusedw  (rfr)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] q[$];

  typedef struct {
    logic        dval;
    logic [31:0] d;
    logic        re_rd, re_wr;
    int          rcnt, wcnt;
    logic [31:0] rdata;
  } vec_t;
  vec_t tv[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string name, input logic ere, input logic erf,
                            input logic ewe, input logic ewf, input int rcnt, input int wcnt);
    logic [8:0] r9, w9;
    r9 = 9'(rcnt);
    w9 = 9'(wcnt);
    check(name, {re_rd, wf_rd, re_wr, wf_wr, rfw, rfr, wfw, wfr},
                {ere, erf, ewe, ewf, r9, r9, w9, w9});
  endtask

  task automatic chk_idle_outputs(input string name);
    check(name, {vpg_pclk, vpg_de, vpg_hs, vpg_vs, vpg_data}, 64'h0);
  endtask

  // Starts video and checks every ctrl_clk cycle against a timing/scoreboard model.
  // Cycle c=0 is the first negedge after read_init is latched.
  task automatic run_video(input int ncyc, input string tag);
    read_init = 1'b1;
    @(negedge ctrl_clk);
    read_init = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      logic        ep, ed, eh, ev;
      logic [23:0] edat;
      logic [31:0] hd;
      int          p, h, v;
      ep = c[0];
      ed = 1'b0; eh = 1'b0; ev = 1'b0;
      if (c > 0) begin
        p  = (c - 1) / 2;
        h  = p % (HA + HB);
        v  = (p / (HA + HB)) % (VA + VB);
        ed = (h < HA) && (v < VA);
        eh = (h >= HA) && (h < HA + 8);
        ev = (v >= VA) && (v < VA + 2);
      end
      hd   = (q.size() > 0) ? q[0] : 32'h0;
      edat = (ed && q.size() > 0) ? hd[23:0] : 24'h0;
      check(tag, {vpg_pclk, vpg_de, vpg_hs, vpg_vs, vpg_data}, {ep, ed, eh, ev, edat});
      if (!ep && ed && q.size() > 0) void'(q.pop_front());
      @(negedge ctrl_clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sCCD_DVAL = 1'b0;
    read_init = 1'b0;
    @(negedge ctrl_clk);
    @(negedge ctrl_clk);
    reset = 1'b0;
    q.delete();
  endtask

  initial begin
    iData = '0;
    tv[0] = '{1'b1, 32'hA1A1_0001, 1'b1, 1'b0, 0, 1, 32'h0};
    tv[1] = '{1'b1, 32'hB2B2_0002, 1'b0, 1'b0, 1, 1, 32'hA1A1_0001};
    tv[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 2, 0, 32'hA1A1_0001};
    tv[3] = '{1'b1, 32'hC3C3_0003, 1'b0, 1'b0, 2, 1, 32'hA1A1_0001};
    tv[4] = '{1'b0, 32'h0,         1'b0, 1'b1, 3, 0, 32'hA1A1_0001};
    tv[5] = '{1'b0, 32'h0,         1'b0, 1'b1, 3, 0, 32'hA1A1_0001};

    // Reset state
    do_reset();
    chk_status("reset_flags", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    chk_idle_outputs("reset_vpg");
    check("reset_rdata", Read_DATA, 64'h0);

    // Latency / simultaneous push-pop vectors
    for (int i = 0; i < 6; i++) begin
      sCCD_DVAL = tv[i].dval;
      iData     = tv[i].d;
      @(negedge ctrl_clk);
      chk_status($sformatf("vec%0d_status", i), tv[i].re_rd, 1'b0, tv[i].re_wr, 1'b0,
                 tv[i].rcnt, tv[i].wcnt);
      check($sformatf("vec%0d_rdata", i), Read_DATA, tv[i].rdata);
    end
    sCCD_DVAL = 1'b0;

    // Burst of 640 words, then drain through a full frame plus wrap
    do_reset();
    for (int i = 1; i <= 640; i++) begin
      iData = 32'(i);
      sCCD_DVAL = 1'b1;
      q.push_back(32'(i));
      @(negedge ctrl_clk);
    end
    sCCD_DVAL = 1'b0;
    @(negedge ctrl_clk);
    chk_status("burst_status", 1'b0, 1'b1, 1'b0, 1'b0, 0, 128);
    check("burst_head", Read_DATA, 64'd1);
    run_video(2 * (HA + HB) * (VA + VB) + 40, "burst_video");
    check("burst_drained", 64'(q.size()), 64'd0);
    chk_status("burst_empty", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

    // Overflow: 1100 words, only 1024 retained
    do_reset();
    for (int i = 1; i <= 1100; i++) begin
      iData = 32'(i);
      sCCD_DVAL = 1'b1;
      if (i <= 1024) q.push_back(32'(i));
      @(negedge ctrl_clk);
    end
    sCCD_DVAL = 1'b0;
    @(negedge ctrl_clk);
    chk_status("ovf_status", 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    check("ovf_head", Read_DATA, 64'd1);
    run_video(1000, "ovf_video");

    // Reset mid-frame with data still queued
    reset = 1'b1;
    @(negedge ctrl_clk);
    chk_idle_outputs("midrst_vpg");
    chk_status("midrst_flags", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
    check("midrst_rdata", Read_DATA, 64'h0);
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge ctrl_clk);
      chk_idle_outputs($sformatf("midrst_idle%0d", i));
    end

    // Underflow: timing restarts from zero with black output
    run_video(2 * (HA + HB) * (VA + VB) + 40, "underflow_video");
    chk_status("underflow_flags", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus.md
Name: bus

Overview:
- Single-clock pixel bus between the camera capture side and the video output side of the ISP.
- Camera words are queued in a write FIFO, then moved by a transfer engine into a read FIFO.
- A video timing generator drains the read FIFO into the VPG interface, with pixel clock, DE, HS, VS and 24-bit data.
- All four FIFO status flags and the fill counts are exported for debug.

Parameters:
- H_ACTIVE, 320, active pixels per line
- V_ACTIVE, 240, active lines per frame
- H_BLANK, 16, blank pixel periods per line; HS is high for the first 8 of them
- V_BLANK, 4, blank lines per frame; VS is high for the first 2 of them
- FIFO_DEPTH, 512, words per FIFO; fill counts are log2(FIFO_DEPTH) bits

Ports:
- ctrl_clk in 1: sole clock; all logic on its rising edge
- reset in 1: synchronous, active-high reset
- iData in 32: camera pixel word
- sCCD_DVAL in 1: iData valid; one word is written per ctrl_clk while high
- read_init in 1: start video output; latched on first high, cleared only by reset
- Read_DATA out 32: head word of the read FIFO (show-ahead)
- vpg_pclk out 1: pixel clock, ctrl_clk/2, registered toggle
- vpg_de out 1: active-video enable
- vpg_hs out 1: horizontal sync, active-high
- vpg_vs out 1: vertical sync, active-high
- vpg_data out 24: Read_DATA[23:0] when popped, else 0
- read_empty_rdfifo, write_full_rdfifo out 1: read FIFO empty / full
- read_empty_wrfifo, write_full_wrfifo out 1: write FIFO empty / full
- write_fifo_wrusedw, write_fifo_rdusedw out 9: write FIFO count mod 512 (both identical)
- read_fifo_wrusedw, read_fifo_rdusedw out 9: read FIFO count mod 512 (both identical)

Behaviour:
- Reset values:
  - both FIFOs empty; empty flags 1, full flags 0, counts 0
  - vpg_pclk, vpg_de, vpg_hs, vpg_vs all 0; vpg_data 0; Read_DATA 0
  - start latch 0; timing counters 0
- Write FIFO:
  - push iData when sCCD_DVAL=1 and not full
  - push while full: word dropped, no state change
- Transfer engine:
  - each cycle where write FIFO is non-empty and read FIFO is not full, pop one word from write FIFO and push it into read FIFO in the same cycle
  - latency from iData to Read_DATA visible is 2 cycles when both FIFOs start empty
- Simultaneous push and pop on a FIFO: count unchanged, data order preserved.
- Full is asserted at count==FIFO_DEPTH, where the 9-bit usedw reads 0; the full flag disambiguates.
- Read FIFO pop: only by the timing generator, on ctrl_clk cycles where vpg_pclk is about to rise (pixel strobe) and vpg_de=1 and not empty.
- Timing generator:
  - idle (all outputs 0) until start latched
  - then hcnt runs 0..H_ACTIVE+H_BLANK-1 and vcnt runs 0..V_ACTIVE+V_BLANK-1, advancing on each pixel strobe and wrapping frame to frame
  - vpg_de=1 when hcnt<H_ACTIVE and vcnt<V_ACTIVE
  - vpg_hs=1 when H_ACTIVE<=hcnt<H_ACTIVE+8
  - vpg_vs=1 when V_ACTIVE<=vcnt<V_ACTIVE+2
  - all registered, changing on the pixel strobe
- Underflow: if de=1 and read FIFO is empty, vpg_data=0, no pop, counters still advance.
- read_init deasserting after start: no effect.
- Reset mid-frame: everything returns to reset values on the next edge; FIFO contents are discarded.

Decomposition:
- Package bus_pkg:
  - FIFO_DEPTH and usedw width
  - video timing constants
  - typedef pixel_t (logic[31:0])
- One sub-module, sync_fifo: single-clock, show-ahead, parameterised depth/width.
  - Ports: push, pop, data in, head data out, empty, full, usedw.
  - Instantiated twice.
- Timing generator and transfer engine stay in bus.

Test Plan:
- Reset: assert reset 2 cycles -> all flags empty=1/full=0, counts 0, vpg_* 0.
- Burst write of 640 words, values 1..640, read_init=0 -> read FIFO fills to 512 (write_full_rdfifo=1, usedw=0), write FIFO holds 128 (write_fifo_wrusedw=128), no loss.
- Then read_init=1 -> vpg_pclk toggles every cycle; first line outputs vpg_data 1,2,...,320 with vpg_de=1 for 320 pixel periods; HS high 8 periods after that; the 640 words emerge in order over 2 lines.
- Overflow: write 1100 words with read_init=0 -> 1024 stored, words 1025..1100 dropped; both full flags 1.
- Underflow: read_init=1 with empty FIFOs -> de/hs/vs timing correct (line period 336 pixels, frame 244 lines), vpg_data=0 throughout.
- Reset mid-frame during active output -> next cycle all outputs at reset values; start latch cleared; resumes only after new read_init.
